// File: rtl/triangle_traverser_if.sv
// triangle_traverser_if
//   Bundles the signals of the bounding-box traversal unit.
//   Triangle handshake : tri_valid/tri_ready, tri_ax..tri_cy (10b vertices)
//   Rasterizer link    : ras_ax..ras_cy, ras_x, ras_y out to the rasterizer;
//                        ras_ua/va/wa/a (20b areas) and ras_visible back
//   Fragment handshake : frag_valid/frag_ready, frag_x/y, frag_ua/va/wa/a
//   Status             : done (one-cycle completion pulse)
//   Modports: slave = traverser view, master = environment view
//   (triangle source, rasterizer and fragment sink).
interface triangle_traverser_if;
    logic       tri_valid;
    logic       tri_ready;
    logic [9:0] tri_ax, tri_ay, tri_bx, tri_by, tri_cx, tri_cy;

    logic [9:0]  ras_ax, ras_ay, ras_bx, ras_by, ras_cx, ras_cy;
    logic [9:0]  ras_x, ras_y;
    logic [19:0] ras_ua, ras_va, ras_wa, ras_a;
    logic        ras_visible;

    logic        frag_valid;
    logic        frag_ready;
    logic [9:0]  frag_x, frag_y;
    logic [19:0] frag_ua, frag_va, frag_wa, frag_a;

    logic done;

    modport slave (
        input  tri_valid, tri_ax, tri_ay, tri_bx, tri_by, tri_cx, tri_cy,
        output tri_ready,
        output ras_ax, ras_ay, ras_bx, ras_by, ras_cx, ras_cy, ras_x, ras_y,
        input  ras_ua, ras_va, ras_wa, ras_a, ras_visible,
        output frag_valid, frag_x, frag_y, frag_ua, frag_va, frag_wa, frag_a,
        input  frag_ready,
        output done
    );

    modport master (
        output tri_valid, tri_ax, tri_ay, tri_bx, tri_by, tri_cx, tri_cy,
        input  tri_ready,
        input  ras_ax, ras_ay, ras_bx, ras_by, ras_cx, ras_cy, ras_x, ras_y,
        output ras_ua, ras_va, ras_wa, ras_a, ras_visible,
        input  frag_valid, frag_x, frag_y, frag_ua, frag_va, frag_wa, frag_a,
        output frag_ready,
        input  done
    );
endinterface

// File: rtl/triangle_traverser.sv
// triangle_traverser
//   Sequential bounding-box traversal feeding a combinational rasterizer.
//   Accepts one triangle, walks its screen-clipped bounding box in raster
//   order (one pixel per cycle), and emits every covered pixel with its raw
//   barycentric areas as a fragment.
//   Ports:
//     clk  - clock, all state on the rising edge
//     rst  - asynchronous active-high reset
//     bus  - triangle_traverser_if.slave (triangle in, rasterizer link,
//            fragment out, done pulse)
//   Parameters: WIDTH/HEIGHT screen size; coordinates clip to WIDTH-1/HEIGHT-1.
module triangle_traverser #(
    parameter int unsigned WIDTH  = 640,
    parameter int unsigned HEIGHT = 480
) (
    input logic                  clk,
    input logic                  rst,
    triangle_traverser_if.slave  bus
);

    localparam logic [9:0] XLIM = 10'(WIDTH - 1);
    localparam logic [9:0] YLIM = 10'(HEIGHT - 1);

    typedef enum logic [1:0] {IDLE, SETUP, SCAN, DONE} state_t;

    state_t      state;
    logic [9:0]  ax, ay, bx, by, cx, cy;
    logic [9:0]  px, py;
    logic [9:0]  xmin, xmax, ymax;
    logic        fvalid;
    logic [9:0]  fx, fy;
    logic [19:0] fua, fva, fwa, fa;

    logic [9:0]  lo_x, hi_x, lo_y, hi_y;
    logic        accept, load, advance, last_col, last_px, done_w;

    function automatic logic [9:0] min3(input logic [9:0] a, b, c);
        logic [9:0] m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic logic [9:0] max3(input logic [9:0] a, b, c);
        logic [9:0] m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

    always_comb begin
        lo_x = min3(ax, bx, cx);
        hi_x = max3(ax, bx, cx);
        lo_y = min3(ay, by, cy);
        hi_y = max3(ay, by, cy);
    end

    // A visible pixel may only be captured when the fragment register is
    // free or being emptied this cycle; otherwise the scan stalls on it.
    always_comb begin
        accept   = fvalid && bus.frag_ready;
        load     = (state == SCAN) && bus.ras_visible && (!fvalid || bus.frag_ready);
        advance  = (state == SCAN) && (!bus.ras_visible || load);
        last_col = (px == xmax);
        last_px  = last_col && (py == ymax);
        done_w   = (state == DONE) && (!fvalid || bus.frag_ready);
    end

    assign bus.tri_ready  = (state == IDLE);
    assign bus.done       = done_w;
    assign bus.ras_ax     = ax;
    assign bus.ras_ay     = ay;
    assign bus.ras_bx     = bx;
    assign bus.ras_by     = by;
    assign bus.ras_cx     = cx;
    assign bus.ras_cy     = cy;
    assign bus.ras_x      = px;
    assign bus.ras_y      = py;
    assign bus.frag_valid = fvalid;
    assign bus.frag_x     = fx;
    assign bus.frag_y     = fy;
    assign bus.frag_ua    = fua;
    assign bus.frag_va    = fva;
    assign bus.frag_wa    = fwa;
    assign bus.frag_a     = fa;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            ax     <= '0;
            ay     <= '0;
            bx     <= '0;
            by     <= '0;
            cx     <= '0;
            cy     <= '0;
            px     <= '0;
            py     <= '0;
            xmin   <= '0;
            xmax   <= '0;
            ymax   <= '0;
            fvalid <= 1'b0;
            fx     <= '0;
            fy     <= '0;
            fua    <= '0;
            fva    <= '0;
            fwa    <= '0;
            fa     <= '0;
        end else begin
            // The fragment register drains in every state; it only fills in SCAN.
            if (load) begin
                fvalid <= 1'b1;
                fx     <= px;
                fy     <= py;
                fua    <= bus.ras_ua;
                fva    <= bus.ras_va;
                fwa    <= bus.ras_wa;
                fa     <= bus.ras_a;
            end else if (accept) begin
                fvalid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (bus.tri_valid) begin
                        ax    <= bus.tri_ax;
                        ay    <= bus.tri_ay;
                        bx    <= bus.tri_bx;
                        by    <= bus.tri_by;
                        cx    <= bus.tri_cx;
                        cy    <= bus.tri_cy;
                        state <= SETUP;
                    end
                end
                SETUP: begin
                    xmin <= lo_x;
                    xmax <= (hi_x > XLIM) ? XLIM : hi_x;
                    ymax <= (hi_y > YLIM) ? YLIM : hi_y;
                    // Triangle area does not depend on the pixel, so the
                    // rasterizer's ras_a is already valid here.
                    if (lo_x > XLIM || lo_y > YLIM || bus.ras_a == '0) begin
                        state <= DONE;
                    end else begin
                        px    <= lo_x;
                        py    <= lo_y;
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    if (advance) begin
                        if (last_px) begin
                            state <= DONE;
                        end else if (last_col) begin
                            px <= xmin;
                            py <= py + 10'd1;
                        end else begin
                            px <= px + 10'd1;
                        end
                    end
                end
                DONE: begin
                    if (done_w) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_triangle_traverser.sv
// tb_triangle_traverser
//   Self-checking bench for triangle_traverser. Provides a behavioural
//   rasterizer (edge functions, sign-normalised), a reference model that
//   enumerates the expected fragments of a triangle in raster order, a table
//   of directed triangles, hand-written reset/stall sequences and randomized
//   triangles with random downstream back-pressure.
module tb_triangle_traverser;

    localparam int W = 640;
    localparam int H = 480;
    localparam int MAXCYC = 20000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    triangle_traverser_if ifc ();

    triangle_traverser #(.WIDTH(W), .HEIGHT(H)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    typedef struct {
        int x, y, ua, va, wa, a;
    } frag_t;

    typedef struct {
        int ax, ay, bx, by, cx, cy;
        int exp_frags;
        int exp_done;
    } vec_t;

    int errors = 0;
    int checks = 0;
    frag_t exp_q[$];

    function automatic int edgef(input int x0, y0, x1, y1, px, py);
        return (x1 - x0) * (py - y0) - (y1 - y0) * (px - x0);
    endfunction

    // Behavioural rasterizer: areas for the current pixel, positive for
    // either winding.
    int r_a, r_u, r_v, r_w;
    always_comb begin
        r_a = edgef(int'(ifc.ras_ax), int'(ifc.ras_ay), int'(ifc.ras_bx),
                    int'(ifc.ras_by), int'(ifc.ras_cx), int'(ifc.ras_cy));
        r_u = edgef(int'(ifc.ras_bx), int'(ifc.ras_by), int'(ifc.ras_cx),
                    int'(ifc.ras_cy), int'(ifc.ras_x), int'(ifc.ras_y));
        r_v = edgef(int'(ifc.ras_cx), int'(ifc.ras_cy), int'(ifc.ras_ax),
                    int'(ifc.ras_ay), int'(ifc.ras_x), int'(ifc.ras_y));
        r_w = edgef(int'(ifc.ras_ax), int'(ifc.ras_ay), int'(ifc.ras_bx),
                    int'(ifc.ras_by), int'(ifc.ras_x), int'(ifc.ras_y));
        if (r_a < 0) begin
            r_a = -r_a;
            r_u = -r_u;
            r_v = -r_v;
            r_w = -r_w;
        end
        ifc.ras_a       = 20'(r_a);
        ifc.ras_ua      = 20'(r_u);
        ifc.ras_va      = 20'(r_v);
        ifc.ras_wa      = 20'(r_w);
        ifc.ras_visible = (r_a != 0) && (r_u >= 0) && (r_v >= 0) && (r_w >= 0);
    end

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    task automatic fail(input string name, input int got, input int want);
        checks++;
        errors++;
        $display("FAIL %s: got %0d, expected %0d", name, got, want);
    endtask

    // Reference model: clipped bounding box, every covered pixel in raster order.
    task automatic build_model(input int ax, ay, bx, by, cx, cy, output int bbox);
        int xl, xh, yl, yh, area, s, u, v, w;
        exp_q.delete();
        xl = (ax < bx) ? ax : bx;  xl = (cx < xl) ? cx : xl;
        xh = (ax > bx) ? ax : bx;  xh = (cx > xh) ? cx : xh;
        yl = (ay < by) ? ay : by;  yl = (cy < yl) ? cy : yl;
        yh = (ay > by) ? ay : by;  yh = (cy > yh) ? cy : yh;
        if (xh > W - 1) xh = W - 1;
        if (yh > H - 1) yh = H - 1;
        area = edgef(ax, ay, bx, by, cx, cy);
        bbox = 0;
        if (xl > W - 1 || yl > H - 1 || area == 0) return;
        bbox = (xh - xl + 1) * (yh - yl + 1);
        s = (area < 0) ? -1 : 1;
        for (int y = yl; y <= yh; y++) begin
            for (int x = xl; x <= xh; x++) begin
                u = s * edgef(bx, by, cx, cy, x, y);
                v = s * edgef(cx, cy, ax, ay, x, y);
                w = s * edgef(ax, ay, bx, by, x, y);
                if (u >= 0 && v >= 0 && w >= 0)
                    exp_q.push_back('{x, y, u, v, w, s * area});
            end
        end
    endtask

    // Offers one triangle, then follows it cycle by cycle (cycle 0 is the
    // handshake cycle) with frag_ready low for roughly stall% of cycles.
    task automatic run_tri(input int ax, ay, bx, by, cx, cy, input int stall,
                           output int nfrag, output int done_cyc, output int bbox);
        frag_t e, held;
        bit hold;
        build_model(ax, ay, bx, by, cx, cy, bbox);
        nfrag = 0;
        done_cyc = -1;
        hold = 1'b0;
        @(negedge clk);
        ifc.tri_ax = 10'(ax);  ifc.tri_ay = 10'(ay);
        ifc.tri_bx = 10'(bx);  ifc.tri_by = 10'(by);
        ifc.tri_cx = 10'(cx);  ifc.tri_cy = 10'(cy);
        ifc.tri_valid  = 1'b1;
        ifc.frag_ready = 1'b1;
        #1 check("tri_ready_idle", int'(ifc.tri_ready), 1);
        @(posedge clk);
        #1 ifc.tri_valid = 1'b0;
        for (int cyc = 1; cyc <= MAXCYC && done_cyc < 0; cyc++) begin
            @(negedge clk);
            ifc.frag_ready = ($urandom_range(0, 99) >= stall);
            #1;
            if (hold) begin
                check("stall_valid", int'(ifc.frag_valid), 1);
                check("stall_x",  int'(ifc.frag_x),  held.x);
                check("stall_y",  int'(ifc.frag_y),  held.y);
                check("stall_ua", int'(ifc.frag_ua), held.ua);
                check("stall_va", int'(ifc.frag_va), held.va);
                check("stall_wa", int'(ifc.frag_wa), held.wa);
                check("stall_a",  int'(ifc.frag_a),  held.a);
                hold = 1'b0;
            end
            if (ifc.frag_valid && ifc.frag_ready) begin
                nfrag++;
                check("frag_x_clip", int'(ifc.frag_x <= 10'(W - 1)), 1);
                if (exp_q.size() == 0) begin
                    fail("extra_frag", nfrag, nfrag - 1);
                end else begin
                    e = exp_q.pop_front();
                    check("frag_x",  int'(ifc.frag_x),  e.x);
                    check("frag_y",  int'(ifc.frag_y),  e.y);
                    check("frag_ua", int'(ifc.frag_ua), e.ua);
                    check("frag_va", int'(ifc.frag_va), e.va);
                    check("frag_wa", int'(ifc.frag_wa), e.wa);
                    check("frag_a",  int'(ifc.frag_a),  e.a);
                end
            end else if (ifc.frag_valid) begin
                hold = 1'b1;
                held = '{int'(ifc.frag_x), int'(ifc.frag_y), int'(ifc.frag_ua),
                         int'(ifc.frag_va), int'(ifc.frag_wa), int'(ifc.frag_a)};
            end
            if (ifc.done) begin
                done_cyc = cyc;
                check("frags_left_at_done", exp_q.size(), 0);
            end
        end
        if (done_cyc < 0) begin
            fail("done_timeout", -1, MAXCYC);
        end else begin
            @(negedge clk);
            ifc.frag_ready = 1'b1;
            #1;
            check("tri_ready_after_done", int'(ifc.tri_ready), 1);
            check("done_one_pulse", int'(ifc.done), 0);
            check("frag_valid_after_done", int'(ifc.frag_valid), 0);
        end
    endtask

    vec_t vecs[$];
    int nfrag, done_cyc, bbox, stall, ax, ay, bx, by, cx, cy;

    initial begin
        ifc.tri_valid = 1'b0;
        ifc.frag_ready = 1'b0;
        ifc.tri_ax = '0; ifc.tri_ay = '0; ifc.tri_bx = '0;
        ifc.tri_by = '0; ifc.tri_cx = '0; ifc.tri_cy = '0;

        vecs.push_back('{0,   0,  4,   0,  0,   4,  15,    27});
        vecs.push_back('{0,   0,  0,   4,  4,   0,  15,    27});
        vecs.push_back('{600, 10, 700, 10, 600, 60, 1640,  2042});
        vecs.push_back('{640, 0,  700, 5,  650, 40, 0,     2});
        vecs.push_back('{0,   0,  2,   2,  4,   4,  0,     2});

        // Reset state, sampled while reset is still held.
        repeat (2) @(negedge clk);
        #1;
        check("rst_tri_ready",  int'(ifc.tri_ready),  1);
        check("rst_frag_valid", int'(ifc.frag_valid), 0);
        check("rst_done",       int'(ifc.done),       0);
        check("rst_ras_x",      int'(ifc.ras_x),      0);
        check("rst_ras_y",      int'(ifc.ras_y),      0);
        check("rst_ras_ax",     int'(ifc.ras_ax),     0);
        @(negedge clk);
        rst = 1'b0;

        // Directed table, no back-pressure.
        foreach (vecs[i]) begin
            run_tri(vecs[i].ax, vecs[i].ay, vecs[i].bx, vecs[i].by,
                    vecs[i].cx, vecs[i].cy, 0, nfrag, done_cyc, bbox);
            check($sformatf("vec%0d_frags", i), nfrag, vecs[i].exp_frags);
            check($sformatf("vec%0d_done_cycle", i), done_cyc, vecs[i].exp_done);
        end

        // Same small triangle under heavy random back-pressure.
        run_tri(0, 0, 4, 0, 0, 4, 50, nfrag, done_cyc, bbox);
        check("stall_tri_frags", nfrag, 15);

        // Asynchronous reset mid-SCAN with a held fragment.
        @(negedge clk);
        ifc.tri_ax = 10'd0; ifc.tri_ay = 10'd0;
        ifc.tri_bx = 10'd4; ifc.tri_by = 10'd0;
        ifc.tri_cx = 10'd0; ifc.tri_cy = 10'd4;
        ifc.tri_valid  = 1'b1;
        ifc.frag_ready = 1'b0;
        @(posedge clk);
        #1 ifc.tri_valid = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        check("pre_rst_frag_valid", int'(ifc.frag_valid), 1);
        check("pre_rst_tri_ready",  int'(ifc.tri_ready),  0);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_frag_valid", int'(ifc.frag_valid), 0);
        check("mid_rst_tri_ready",  int'(ifc.tri_ready),  1);
        check("mid_rst_done",       int'(ifc.done),       0);
        check("mid_rst_ras_x",      int'(ifc.ras_x),      0);
        @(negedge clk);
        rst = 1'b0;
        ifc.frag_ready = 1'b1;
        run_tri(0, 0, 4, 0, 0, 4, 0, nfrag, done_cyc, bbox);
        check("post_rst_frags", nfrag, 15);
        check("post_rst_done_cycle", done_cyc, 27);

        // Random triangles, some straddling the right screen edge.
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 3) == 0) begin
                ax = $urandom_range(610, 680); bx = $urandom_range(610, 680);
                cx = $urandom_range(610, 680);
            end else begin
                ax = $urandom_range(0, 24); bx = $urandom_range(0, 24);
                cx = $urandom_range(0, 24);
            end
            ay = $urandom_range(0, 20); by = $urandom_range(0, 20);
            cy = $urandom_range(0, 20);
            stall = ($urandom_range(0, 1) == 0) ? 0 : 40;
            run_tri(ax, ay, bx, by, cx, cy, stall, nfrag, done_cyc, bbox);
            if (stall == 0)
                check($sformatf("rand%0d_done_cycle", t), done_cyc, 2 + bbox);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
